// File: rtl/uart_tx_fsm_top.sv
// uart_tx_fsm_top: UART transmitter (start, DATA_WIDTH bits LSB-first, optional parity, stop; one bit per clk); ports clk, rst, p_data, data_valid, par_en, par_typ -> tx_out (idle high, registered), busy
module uart_tx_fsm_top #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt, sh;
  logic                  par_en_q, par_en_nxt, par_typ_q, par_typ_nxt, tx_nxt, busy_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      data_q    <= data_nxt;
      par_en_q  <= par_en_nxt;
      par_typ_q <= par_typ_nxt;
      tx_out    <= tx_nxt;
      busy      <= busy_nxt;
    end
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    data_nxt    = data_q;
    par_en_nxt  = par_en_q;
    par_typ_nxt = par_typ_q;
    case (state)
      IDLE: if (data_valid) begin
        state_nxt   = START;
        data_nxt    = p_data;
        par_en_nxt  = par_en;
        par_typ_nxt = par_typ;
      end
      START:  state_nxt = DATA;
      DATA: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(DATA_WIDTH - 1)) begin
          state_nxt = par_en_q ? PARITY : STOP;
          cnt_nxt   = '0;
        end
      end
      PARITY: state_nxt = STOP;
      STOP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    sh       = data_nxt >> cnt_nxt;
    tx_nxt   = state_nxt == START  ? 1'b0 :
               state_nxt == DATA   ? sh[0] :
               state_nxt == PARITY ? (^data_q) ^ par_typ_q : 1'b1;
    busy_nxt = state_nxt != IDLE;
  end
endmodule

// File: tb/tb_uart_tx_fsm_top.sv
// tb_uart_tx_fsm_top: randomized scoreboard bench for uart_tx_fsm_top
module tb_uart_tx_fsm_top;
  logic       clk = 1'b0, rst = 1'b1, data_valid = 1'b0, par_en = 1'b0, par_typ = 1'b0;
  logic [7:0] p_data = '0;
  logic       tx_out, busy;
  typedef struct { logic [15:0] bits; int len; } frame_t;
  frame_t exp_q[$];
  frame_t cur;
  int     checks = 0, failures = 0, idx = 0, gap = 100, last_gap = 100;
  bit     active = 0;

  uart_tx_fsm_top #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic frame_t model(input logic [7:0] d, input bit pe, input bit pt);
    frame_t f;
    int n = 0;
    f.bits = '0;
    f.bits[n++] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[n++] = d[i];
    if (pe) f.bits[n++] = logic'(($countones(d) % 2) == 1) ^ pt;
    f.bits[n++] = 1'b1;
    f.len = n;
    return f;
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst) begin
      active = 0;
      exp_q.delete();
    end else if (active) begin
      if (idx < cur.len) begin
        chk("busy_in_frame", busy, 1'b1);
        chk("tx_bit", tx_out, cur.bits[idx]);
        idx++;
      end else begin
        chk("busy_after_stop", busy, 1'b0);
        chk("tx_after_stop", tx_out, 1'b1);
        active = 0;
        gap = 1;
      end
    end else if (busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame actual=busy expected=idle t=%0t", $time);
      end else begin
        cur = exp_q.pop_front();
        chk("tx_start", tx_out, cur.bits[0]);
        idx = 1;
        active = 1;
        last_gap = gap;
      end
    end else begin
      chk("tx_idle", tx_out, 1'b1);
      gap++;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy expected=idle t=%0t", $time);
    end
  endtask

  task automatic issue(input logic [7:0] d, input bit pe, input bit pt);
    p_data = d;
    par_en = pe;
    par_typ = pt;
    data_valid = 1'b1;
    exp_q.push_back(model(d, pe, pt));
  endtask

  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input bit disturb);
    wait_idle();
    issue(d, pe, pt);
    @(negedge clk);
    data_valid = 1'b0;
    if (disturb)
      repeat (4) begin
        @(negedge clk);
        p_data = 8'($urandom);
        par_en = 1'($urandom);
        par_typ = 1'($urandom);
        data_valid = 1'($urandom);
      end
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("reset_tx", tx_out, 1'b1);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    send(8'hA5, 1, 0, 0);
    send(8'hA5, 1, 1, 0);
    send(8'h3C, 0, 0, 0);
    wait_idle();
    issue(8'h5A, 1, 0);
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    p_data = 8'hFF;
    par_typ = 1'b1;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    p_data = 8'h00;
    wait_idle();
    repeat (3) @(negedge clk);
    issue(8'h55, 1, 0);
    @(negedge clk);
    wait_idle();
    p_data = 8'hAA;
    exp_q.push_back(model(8'hAA, 1, 0));
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    chk("one_idle_bit_gap", 1'(last_gap == 1), 1'b1);
    wait_idle();
    issue(8'hC3, 1, 1);
    repeat (5) @(negedge clk);
    data_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_reset_tx", tx_out, 1'b1);
    chk("async_reset_busy", busy, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_reset_idle", busy, 1'b0);
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n = 0;
    while ((exp_q.size() != 0 || active) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fsm_top.md
Name: uart_tx_fsm_top

Overview:
UART transmitter: the companion to the UART receive path in the same communication system. It accepts a parallel byte on a valid strobe, then serialises it as start bit, data bits LSB-first, an optional parity bit and a stop bit, one bit per clock. It runs on the divided TX bit clock and sits between the async FIFO read side and the serial pad. Internally it has a control FSM, a serializer, a parity calculator and a registered output mux.

Parameters:
DATA_WIDTH, 8, number of data bits per frame

Ports:
clk  input  1  TX bit clock; one serial bit per cycle
rst  input  1  asynchronous, active-high reset
p_data  input  DATA_WIDTH  parallel data to send
data_valid  input  1  request strobe; accepted only when busy=0
par_en  input  1  1 = append parity bit
par_typ  input  1  0 = even parity, 1 = odd parity
tx_out  output  1  serial line, idle high
busy  output  1  high while a frame is in progress

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst=1: FSM goes to IDLE, tx_out=1, busy=0, bit counter=0, latched data and config cleared. This applies immediately, including mid-frame. The aborted frame is dropped, not resumed.
- FSM states are IDLE, START, DATA, PARITY, STOP. Outputs are registered, so tx_out and busy change only on the clk edge.
- IDLE: tx_out=1, busy=0.
  - If data_valid=1 at an edge, latch p_data, par_en and par_typ, then move to START.
  - Otherwise stay in IDLE.
- Timing relative to the accepting edge at cycle N:
  - Cycle N+1: START, tx_out=0, busy=1.
  - Cycles N+2 to N+1+DATA_WIDTH: DATA, tx_out = latched_data[i] with i = 0..DATA_WIDTH-1 (LSB first).
  - Next cycle, if latched par_en=1: PARITY, tx_out = parity bit.
  - Then STOP, tx_out=1, busy=1.
  - Then IDLE, busy=0.
- Frame length is DATA_WIDTH+3 cycles with parity and DATA_WIDTH+2 without (11 and 10 for the default width).
- Bit counter: clog2(DATA_WIDTH)+1 bits.
  - Clears on entry to DATA and increments each DATA cycle.
  - DATA exits after the bit at index DATA_WIDTH-1.
  - Counter is held at 0 outside DATA.
- Parity is computed from the latched data, never from live p_data.
  - Even: XOR of all data bits.
  - Odd: inverted XOR.
- Config and data are sampled only at acceptance. Changes on p_data, par_en or par_typ mid-frame have no effect on the current frame.
- Handshake:
  - data_valid while busy=1 is ignored and not queued. The upstream must hold or re-assert it.
  - data_valid held high continuously: the next frame is accepted in the first IDLE cycle. This gives exactly one idle-high bit between consecutive stop and start bits.
- No illegal-state lockup: an unreachable state encoding returns to IDLE on the next edge with tx_out=1 and busy=0.
- tx_out must be glitch-free, driven directly from a flop.

Test Plan:
- Reset then idle with no data_valid -> tx_out=1 and busy=0 indefinitely.
- p_data=0xA5, par_en=1, par_typ=0, pulse data_valid -> from N+1, tx_out sequence 0,1,0,1,0,0,1,0,1,0,1; busy=1 for exactly 11 cycles, then 0.
- Same data with par_typ=1 -> 0,1,0,1,0,0,1,0,1,1,1.
- p_data=0x3C, par_en=0 -> sequence 0,0,0,1,1,1,1,0,0,1; busy high for 10 cycles.
- Pulse data_valid with p_data=0xFF mid-frame, and change p_data/par_typ mid-frame -> current frame bits unchanged, no second frame sent.
- data_valid held high with 0x55 then 0xAA -> stop bit, one idle 1, then the next start bit.
- Assert rst at the 4th data bit -> tx_out=1 and busy=0 immediately, without waiting for a clock edge. After release the line stays idle until a new data_valid.
